// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// axi_lite_pkg : AXI4-Lite bus types, response codes and address decode.
// Rev 1.0
// ============================================================================
package axi_lite_pkg;

   localparam int ADDR_WIDTH  = 32;
   localparam int DATA_WIDTH  = 32;
   localparam int STRB_WIDTH  = DATA_WIDTH / 8;
   localparam int BUFFER_SIZE = 32;
   localparam int ADDR_LSB    = $clog2(STRB_WIDTH);

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [STRB_WIDTH-1:0] strb_t;
   typedef logic [1:0]            resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   // Range is checked on the wrapped offset, so addresses below base decode as DECERR.
   function automatic resp_t decode_resp(input addr_t addr, input addr_t base,
                                         input int unsigned depth);
      addr_t                off;
      logic [ADDR_WIDTH:0]  span;
      off  = addr - base;
      span = (ADDR_WIDTH+1)'(depth) << ADDR_LSB;
      if ({1'b0, off} >= span)
         return RESP_DECERR;
      if (addr[ADDR_LSB-1:0] != '0)
         return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_slave_mem_if.sv
`default_nettype none
// ============================================================================
// axi_lite_slave_mem_if : AXI4-Lite AW/W/B/AR/R channel bundle.
// Rev 1.0
// ============================================================================
interface axi_lite_slave_mem_if;
   import axi_lite_pkg::*;

   addr_t awaddr;
   logic  awvalid;
   logic  awready;
   data_t wdata;
   strb_t wstrb;
   logic  wvalid;
   logic  wready;
   resp_t bresp;
   logic  bvalid;
   logic  bready;
   addr_t araddr;
   logic  arvalid;
   logic  arready;
   data_t rdata;
   resp_t rresp;
   logic  rvalid;
   logic  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface
`default_nettype wire

// File: rtl/axi_lite_mem_array.sv
`default_nettype none
// ============================================================================
// axi_lite_mem_array : word store with one byte-strobed write port and one
//                      asynchronous read port; cleared by reset.
// Rev 1.0
// ============================================================================
module axi_lite_mem_array
   import axi_lite_pkg::*;
#(
   parameter int DEPTH = BUFFER_SIZE,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [IDX_W-1:0] widx_i,
   input  data_t            wdata_i,
   input  strb_t            wstrb_i,
   input  logic [IDX_W-1:0] ridx_i,
   output data_t            rdata_o
);

   data_t mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (we_i) begin
         for (int b = 0; b < STRB_WIDTH; b++)
            if (wstrb_i[b])
               mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

   // Read is combinational so a read sampled on a write edge sees the old word.
   assign rdata_o = mem_q[ridx_i];

endmodule
`default_nettype wire

// File: rtl/axi_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// axi_lite_slave_mem : AXI4-Lite slave terminating the bus into a DEPTH x 32
//                      word store with byte strobes.
// Rev 1.0
// ============================================================================
module axi_lite_slave_mem
   import axi_lite_pkg::*;
#(
   parameter int    DEPTH     = BUFFER_SIZE,
   parameter addr_t BASE_ADDR = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_lite_slave_mem_if.slave   bus
);

   localparam int IDX_W = $clog2(DEPTH);

   logic  aw_held_q, aw_held_d;
   addr_t awaddr_q,  awaddr_d;
   logic  w_held_q,  w_held_d;
   data_t wdata_q,   wdata_d;
   strb_t wstrb_q,   wstrb_d;
   logic  bvalid_q,  bvalid_d;
   resp_t bresp_q,   bresp_d;
   logic  rvalid_q,  rvalid_d;
   data_t rdata_q,   rdata_d;
   resp_t rresp_q,   rresp_d;

   logic             aw_hs;
   logic             w_hs;
   logic             ar_hs;
   logic             commit;
   logic             mem_we;
   resp_t            wr_resp;
   resp_t            rd_resp;
   logic [IDX_W-1:0] widx;
   logic [IDX_W-1:0] ridx;
   data_t            mem_rdata;

   assign aw_hs   = bus.awvalid && !aw_held_q;
   assign w_hs    = bus.wvalid  && !w_held_q;
   assign ar_hs   = bus.arvalid && (!rvalid_q || bus.rready);
   // A write may retire only when the B slot is free or being emptied this edge.
   assign commit  = aw_held_q && w_held_q && (!bvalid_q || bus.bready);

   assign wr_resp = decode_resp(awaddr_q,   BASE_ADDR, DEPTH);
   assign rd_resp = decode_resp(bus.araddr, BASE_ADDR, DEPTH);
   assign widx    = IDX_W'((awaddr_q   - BASE_ADDR) >> ADDR_LSB);
   assign ridx    = IDX_W'((bus.araddr - BASE_ADDR) >> ADDR_LSB);
   assign mem_we  = commit && (wr_resp == RESP_OKAY);

   always_comb begin
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         awaddr_d  = bus.awaddr;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = bus.wdata;
         wstrb_d  = bus.wstrb;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_resp;
      end else if (bus.bready) begin
         bvalid_d  = 1'b0;
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_resp;
         rdata_d  = (rd_resp == RESP_OKAY) ? mem_rdata : '0;
      end else if (bus.rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_held_q <= 1'b0;
         awaddr_q  <= '0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   axi_lite_mem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (mem_we),
      .widx_i  (widx),
      .wdata_i (wdata_q),
      .wstrb_i (wstrb_q),
      .ridx_i  (ridx),
      .rdata_o (mem_rdata)
   );

   assign bus.awready = !aw_held_q;
   assign bus.wready  = !w_held_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = !rvalid_q || bus.rready;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_slave_mem : scoreboard bench, word-level reference memory.
// Rev 1.0
// ============================================================================
module tb_axi_lite_slave_mem;

   localparam int          DEPTH  = 32;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int          BUDGET = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axi_lite_slave_mem_if bus ();

   axi_lite_slave_mem #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] model [int];
   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];
   int          r_cyc [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail(input string msg);
      n_checks++;
      $display("FAIL %s (t=%0t)", msg, $time);
   endtask

   function automatic logic [1:0] ref_resp(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off >= 32'(DEPTH * 4)) return 2'b11;
      if (a[1:0] != 2'b00)       return 2'b10;
      return 2'b00;
   endfunction

   function automatic int ref_idx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] ref_word(input int idx);
      return model.exists(idx) ? model[idx] : 32'h0;
   endfunction

   function automatic logic [31:0] rand_addr();
      int          k;
      logic [31:0] w;
      k = int'($urandom_range(0, 9));
      w = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (k < 7) return BASE + w;
      if (k < 8) return BASE + w + 32'($urandom_range(1, 3));
      if (k < 9) return BASE + 32'(DEPTH * 4) + ($urandom & 32'h0000_0FFC);
      return BASE - 32'd4;
   endfunction

   // Monitor: pops one expectation per completed B or R handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.bvalid && bus.bready) begin
            if (exp_b.size() == 0) fail($sformatf("unexpected B beat, bresp=%0d", bus.bresp));
            else check("B bresp", 64'(bus.bresp), 64'(exp_b.pop_front()));
         end
         if (bus.rvalid && bus.rready) begin
            r_cyc.push_back(cyc);
            if (exp_r.size() == 0) fail($sformatf("unexpected R beat, rdata=0x%0h", bus.rdata));
            else check("R {rresp,rdata}", 64'({bus.rresp, bus.rdata}), 64'(exp_r.pop_front()));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the handshake edge.
   task automatic wait_accept(input int ch, input string name);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if ((ch == 0 && bus.awready) || (ch == 1 && bus.wready) || (ch == 2 && bus.arready)) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         n++;
         if (n >= BUDGET) begin
            fail($sformatf("%s handshake timeout: waited %0d cycles, required < %0d", name, n, BUDGET));
            break;
         end
      end
   endtask

   task automatic send_aw(input logic [31:0] a, input int dly);
      repeat (dly) begin @(posedge clk); #1; end
      bus.awaddr  = a;
      bus.awvalid = 1'b1;
      wait_accept(0, "AW");
      bus.awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
      repeat (dly) begin @(posedge clk); #1; end
      bus.wdata  = d;
      bus.wstrb  = s;
      bus.wvalid = 1'b1;
      wait_accept(1, "W");
      bus.wvalid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
      logic [1:0]  r;
      logic [31:0] w;
      r = ref_resp(a);
      exp_b.push_back(r);
      if (r == 2'b00) begin
         w = ref_word(ref_idx(a));
         for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
         model[ref_idx(a)] = w;
      end
      fork
         send_aw(a, aw_dly);
         send_w(d, s, w_dly);
      join
   endtask

   task automatic do_read_exp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      exp_r.push_back({r, d});
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      wait_accept(2, "AR");
      bus.arvalid = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a);
      logic [1:0] r;
      r = ref_resp(a);
      do_read_exp(a, (r == 2'b00) ? ref_word(ref_idx(a)) : 32'h0, r);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_b.size() != 0 || exp_r.size() != 0) && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= BUDGET) begin
         fail($sformatf("idle timeout: %0d B and %0d R responses outstanding, required 0",
                        exp_b.size(), exp_r.size()));
         exp_b.delete();
         exp_r.delete();
      end
   endtask

   task automatic check_idle_state(input string tag);
      check({tag, " awready"}, 64'(bus.awready), 64'd1);
      check({tag, " wready"},  64'(bus.wready),  64'd1);
      check({tag, " arready"}, 64'(bus.arready), 64'd1);
      check({tag, " bvalid"},  64'(bus.bvalid),  64'd0);
      check({tag, " rvalid"},  64'(bus.rvalid),  64'd0);
      check({tag, " rdata"},   64'(bus.rdata),   64'd0);
      check({tag, " bresp"},   64'(bus.bresp),   64'd0);
      check({tag, " rresp"},   64'(bus.rresp),   64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the bench completed");
      $fatal(1);
   end

   initial begin
      logic [31:0] old;
      bus.awaddr = '0; bus.awvalid = 1'b0;
      bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b1;
      bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b1;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_state("reset");
      @(posedge clk); #1;

      // 1: simultaneous AW/W, two-edge B latency, read back
      do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
      @(negedge clk); check("T1 bvalid after handshake edge", 64'(bus.bvalid), 64'd0);
      @(negedge clk); check("T1 bvalid after commit edge",    64'(bus.bvalid), 64'd1);
      @(posedge clk); #1;
      wait_idle();
      do_read_exp(32'h08, 32'hDEADBEEF, 2'b00);
      wait_idle();

      // 2: W leads AW by three cycles, partial strobes
      do_write(32'h0C, 32'h11223344, 4'hF, 0, 0);
      do_write(32'h0C, 32'hAABBCCDD, 4'b0101, 3, 0);
      wait_idle();
      do_read_exp(32'h0C, 32'h11BB33DD, 2'b00);
      wait_idle();

      // 3: error responses leave memory untouched; wstrb=0 is a no-op
      do_write(32'h04, 32'hCAFEF00D, 4'hF, 0, 0);
      do_write(32'h80, 32'h12345678, 4'hF, 1, 0);
      do_write(32'h06, 32'h87654321, 4'hF, 0, 2);
      do_write(32'hFFFF_FFFC, 32'h55AA55AA, 4'hF, 0, 0);
      do_write(32'h04, 32'hFFFFFFFF, 4'h0, 0, 0);
      wait_idle();
      do_read_exp(32'h04, 32'hCAFEF00D, 2'b00);
      do_read_exp(32'h80, 32'h0, 2'b11);
      do_read_exp(32'h06, 32'h0, 2'b10);
      do_read_exp(32'h7C, 32'h0, 2'b00);
      wait_idle();

      // 4: B back-pressure; a second write is held but not committed
      bus.bready = 1'b0;
      do_write(32'h84, 32'h01010101, 4'hF, 0, 0);
      old = ref_word(6);
      do_write(32'h18, 32'h02020202, 4'hF, 0, 0);
      do_read_exp(32'h18, old, 2'b00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("T4 bvalid held",         64'(bus.bvalid),  64'd1);
         check("T4 bresp held",          64'(bus.bresp),   64'd3);
         check("T4 awready while held",  64'(bus.awready), 64'd0);
         check("T4 wready while held",   64'(bus.wready),  64'd0);
      end
      @(posedge clk); #1;
      bus.bready = 1'b1;
      wait_idle();
      do_read_exp(32'h18, 32'h02020202, 2'b00);
      wait_idle();

      // 5: back-to-back reads, then R stall
      r_cyc.delete();
      do_read(32'h00);
      do_read(32'h04);
      do_read(32'h08);
      wait_idle();
      if (r_cyc.size() == 3) begin
         check("T5 beat spacing 0-1", 64'(r_cyc[1] - r_cyc[0]), 64'd1);
         check("T5 beat spacing 1-2", 64'(r_cyc[2] - r_cyc[1]), 64'd1);
      end else begin
         fail($sformatf("T5 beat count: got %0d, required 3", r_cyc.size()));
      end
      bus.rready = 1'b0;
      do_read(32'h0C);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("T5 arready stalled", 64'(bus.arready), 64'd0);
         check("T5 rvalid held",     64'(bus.rvalid),  64'd1);
         check("T5 rdata held",      64'(bus.rdata),   64'h11BB33DD);
      end
      @(posedge clk); #1;
      bus.rready = 1'b1;
      wait_idle();

      // Collision: read sampled on the commit edge returns the old word
      do_write(32'h14, 32'h55555555, 4'hF, 0, 0);
      wait_idle();
      exp_b.push_back(2'b00);
      bus.awaddr = 32'h14; bus.awvalid = 1'b1;
      bus.wdata  = 32'h66666666; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      exp_r.push_back({2'b00, 32'h55555555});
      bus.araddr = 32'h14; bus.arvalid = 1'b1;
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      model[5] = 32'h66666666;
      wait_idle();
      do_read(32'h14);
      wait_idle();

      // Randomized traffic against the reference memory
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            do_write(rand_addr(), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
            wait_idle();
         end else begin
            do_read(rand_addr());
         end
      end
      wait_idle();
      for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(i * 4));
      wait_idle();

      // 6: reset while AW is held and W never arrives
      do_write(32'h1C, 32'h77777777, 4'hF, 0, 0);
      wait_idle();
      bus.awaddr = 32'h1C; bus.awvalid = 1'b1;
      wait_accept(0, "T6 AW");
      bus.awvalid = 1'b0;
      @(negedge clk);
      check("T6 awready with AW held", 64'(bus.awready), 64'd0);
      #2 rst = 1'b1;
      #1 check("T6 awready async reset", 64'(bus.awready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      model.delete();
      @(negedge clk);
      check_idle_state("T6 after reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("T6 no bvalid", 64'(bus.bvalid), 64'd0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < DEPTH; i++) do_read_exp(BASE + 32'(i * 4), 32'h0, 2'b00);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
